// File: rtl/output_loss_stage.sv
// Output loss stage: registers dL/dy = prediction - target for the output layer,
// pulses a one-cycle training strobe per accepted sample, and reports the batch
// mean-squared loss, epoch count and a sticky converged flag.
//
// Ports:
//   clk, rst (async, active-high), clear (sync zero of batch/epoch/converged state)
//   in_valid/in_ready      : sample handshake; ready only in IDLE
//   predictions, targets   : per-unit vectors of one sample
//   loss_threshold         : converged is set when a reported loss is below this
//   error_gradient         : registered prediction - target, held until next sample
//   training               : one-cycle strobe, the cycle after a sample is accepted
//   batch_loss/loss_valid  : mean-squared loss of the last batch and its update pulse
//   sample_count           : samples accumulated in the current batch
//   epoch_count            : completed batches, wraps modulo 2^EPOCH_BITS
//   converged              : sticky convergence flag
module output_loss_stage #(
  parameter int OUTPUT_UNITS = 2,
  parameter int BATCH_SIZE   = 4,
  parameter int EPOCH_BITS   = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              clear,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  real                               predictions [OUTPUT_UNITS],
  input  real                               targets [OUTPUT_UNITS],
  input  real                               loss_threshold,
  output real                               error_gradient [OUTPUT_UNITS],
  output logic                              training,
  output real                               batch_loss,
  output logic                              loss_valid,
  output logic [$clog2(BATCH_SIZE+1)-1:0]   sample_count,
  output logic [EPOCH_BITS-1:0]             epoch_count,
  output logic                              converged
);

  localparam int CW = $clog2(BATCH_SIZE + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    UPDATE = 2'd1,
    REPORT = 2'd2
  } state_t;

  state_t state;
  real    acc;
  real    sq_sum;
  real    new_loss;
  logic   training_r;
  logic   loss_valid_r;
  logic   accept;

  // Ready is held low throughout reset so nothing is accepted before the
  // stage is known to be in IDLE.
  assign in_ready = (state == IDLE) && !rst;
  assign accept   = in_valid && in_ready;

  // Squared error of the sample currently on the inputs.
  always_comb begin
    sq_sum = 0.0;
    for (int i = 0; i < OUTPUT_UNITS; i++) begin
      sq_sum = sq_sum + (predictions[i] - targets[i]) * (predictions[i] - targets[i]);
    end
  end

  // Mean over every unit of every sample in the batch.
  always_comb begin
    new_loss = acc / real'(BATCH_SIZE * OUTPUT_UNITS);
  end

  // The strobes are registered, but a clear in the cycle they are high
  // still suppresses them, so a cleared stage never triggers an update.
  assign training   = training_r && !clear;
  assign loss_valid = loss_valid_r && !clear;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      acc          <= 0.0;
      batch_loss   <= 0.0;
      training_r   <= 1'b0;
      loss_valid_r <= 1'b0;
      sample_count <= '0;
      epoch_count  <= '0;
      converged    <= 1'b0;
      for (int i = 0; i < OUTPUT_UNITS; i++) begin
        error_gradient[i] <= 0.0;
      end
    end else begin
      training_r   <= 1'b0;
      loss_valid_r <= 1'b0;
      if (clear) begin
        // Any sample offered this cycle is discarded; gradient and last
        // reported loss are deliberately left alone.
        state        <= IDLE;
        acc          <= 0.0;
        sample_count <= '0;
        epoch_count  <= '0;
        converged    <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (accept) begin
              for (int i = 0; i < OUTPUT_UNITS; i++) begin
                error_gradient[i] <= predictions[i] - targets[i];
              end
              acc          <= acc + sq_sum;
              sample_count <= sample_count + CW'(1);
              training_r   <= 1'b1;
              state        <= UPDATE;
            end
          end
          UPDATE: begin
            if (sample_count == CW'(BATCH_SIZE)) begin
              state <= REPORT;
            end else begin
              state <= IDLE;
            end
          end
          REPORT: begin
            batch_loss   <= new_loss;
            loss_valid_r <= 1'b1;
            acc          <= 0.0;
            sample_count <= '0;
            epoch_count  <= epoch_count + EPOCH_BITS'(1);
            if (new_loss < loss_threshold) begin
              converged <= 1'b1;
            end
            state <= IDLE;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule
